spi_slv16: RTL

SPI_SLV16 -- requirements
Module: spi_slv16

---
 rtl/spi_slv16.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_slv16.sv
// rtl/spi_slv16.sv - SPI mode-0 16-bit slave; define SPI_SLV_FRAME_ERR_EN to enable frame_err
module spi_slv16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rdy,
    output logic        frame_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronizer chains: bit 0 is the pin-side flop, bit 2 the edge-detect flop
    logic [2:0] ss_sync_q, ss_sync_d;
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    // Counts the first two clocks after reset so the armed flag only sees
    // synchronizer contents that actually came from the SS_n pin
    logic [1:0] warm_q, warm_d;
    logic       armed_q, armed_d;

    state_t      state_q, state_d;
    logic [15:0] tx_shreg_q, tx_shreg_d;
    logic [15:0] rx_shreg_q, rx_shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;

    logic ss_rise;
    logic ss_fall;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_s;

    // Synchronizer shift and edge detection on the second/third flop pair
    always_comb begin
        ss_sync_d   = {ss_sync_q[1:0], SS_n};
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
        ss_rise     = ss_sync_q[1] & ~ss_sync_q[2];
        ss_fall     = ~ss_sync_q[1] & ss_sync_q[2];
        sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
        mosi_s      = mosi_sync_q[1];
    end

    // Arming: a frame may start only after SS_n has been seen high since reset
    always_comb begin
        warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == 2'd2) & ss_sync_q[1]);
    end

    // FSM next-state and datapath; SS_n rise takes priority over any SCLK edge
    always_comb begin
        state_d    = state_q;
        tx_shreg_d = tx_shreg_q;
        rx_shreg_d = rx_shreg_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rdy_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d    = SHIFT;
                    tx_shreg_d = tx_data;
                    bit_cnt_d  = 5'd0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_q == 5'd16) begin
                        rx_data_d = rx_shreg_q;
                        rdy_d     = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_shreg_d = {rx_shreg_q[14:0], mosi_s};
                    if (bit_cnt_q != 5'd31) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (sclk_fall) begin
                    tx_shreg_d = {tx_shreg_q[14:0], 1'b0};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 2'b00;
            warm_q      <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            tx_shreg_q  <= 16'h0000;
            rx_shreg_q  <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            rx_data_q   <= 16'h0000;
            rdy_q       <= 1'b0;
        end else begin
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            tx_shreg_q  <= tx_shreg_d;
            rx_shreg_q  <= rx_shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rdy_q       <= rdy_d;
        end
    end

    assign MISO    = (state_q == SHIFT) ? tx_shreg_q[15] : 1'b0;
    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;

`ifdef SPI_SLV_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // Frame ends with a bit count other than 16: flag it in the slot rdy would use
    always_comb begin
        frame_err_d = (state_q == SHIFT) && ss_rise && (bit_cnt_q != 5'd16);
    end

    // Error pulse register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
